// File: rtl/zynet_axil_regs.sv
`default_nettype none
// ============================================================================
// Module   : zynet_axil_regs
// Brief    : AXI4-Lite register file for the zyNet core: config, weight/bias
//            strobes, soft reset, result capture, output pop and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module zynet_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int dataWidth          = 16,
  parameter int numOut             = 10
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [3:0]                      s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [31:0]                     layer_no,
  output logic [31:0]                     neuron_no,
  output logic                            weight_valid,
  output logic                            bias_valid,
  output logic [31:0]                     weight_value,
  output logic                            soft_reset,
  input  logic                            out_valid,
  input  logic [31:0]                     out_class,
  input  logic [numOut*dataWidth-1:0]     out_vec,
  output logic                            intr
);

  localparam logic [2:0] c_reg_weight = 3'd0;
  localparam logic [2:0] c_reg_bias   = 3'd1;
  localparam logic [2:0] c_reg_class  = 3'd2;
  localparam logic [2:0] c_reg_layer  = 3'd3;
  localparam logic [2:0] c_reg_neuron = 3'd4;
  localparam logic [2:0] c_reg_pop    = 3'd5;
  localparam logic [2:0] c_reg_status = 3'd6;
  localparam logic [2:0] c_reg_soft   = 3'd7;
  localparam logic [4:0] c_last_idx   = 5'(numOut - 1);

  logic                 r_awready, r_wready, r_bvalid;
  logic                 r_arready, r_rvalid;
  logic [31:0]          r_rdata;
  logic [31:0]          r_layer_no, r_neuron_no, r_soft_reg;
  logic                 r_weight_valid, r_bias_valid;
  logic [31:0]          r_weight_value;
  logic [31:0]          r_class;
  logic                 r_result_valid, r_intr;
  logic [4:0]           r_pop_idx;
  logic [dataWidth-1:0] r_out_mem [numOut];

  logic                 w_wr_fire, w_rd_fire;
  logic [2:0]           w_wr_sel, w_rd_sel;
  logic [31:0]          w_pop_data, w_rd_mux;
  logic                 w_unused;

  assign w_wr_fire = r_awready && s_axi_awvalid && s_axi_wvalid;
  assign w_rd_fire = r_arready && s_axi_arvalid;
  assign w_wr_sel  = s_axi_awaddr[4:2];
  assign w_rd_sel  = s_axi_araddr[4:2];
  assign w_unused  = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic [31:0] f_apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Write channel: address and data are accepted together, one beat at a time.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_awready      <= 1'b0;
      r_wready       <= 1'b0;
      r_bvalid       <= 1'b0;
      r_layer_no     <= '0;
      r_neuron_no    <= '0;
      r_soft_reg     <= 32'd1;
      r_weight_valid <= 1'b0;
      r_bias_valid   <= 1'b0;
      r_weight_value <= '0;
    end else begin
      r_weight_valid <= 1'b0;
      r_bias_valid   <= 1'b0;
      if (w_wr_fire) begin
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        case (w_wr_sel)
          c_reg_weight: begin
            r_weight_valid <= 1'b1;
            r_weight_value <= s_axi_wdata;
          end
          c_reg_bias: begin
            r_bias_valid   <= 1'b1;
            r_weight_value <= s_axi_wdata;
          end
          c_reg_layer:  r_layer_no  <= f_apply_strb(r_layer_no, s_axi_wdata, s_axi_wstrb);
          c_reg_neuron: r_neuron_no <= f_apply_strb(r_neuron_no, s_axi_wdata, s_axi_wstrb);
          c_reg_soft:   r_soft_reg  <= f_apply_strb(r_soft_reg, s_axi_wdata, s_axi_wstrb);
          default: ;
        endcase
      end else if (r_awready) begin
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
      end else if (s_axi_awvalid && s_axi_wvalid && !r_bvalid) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (r_bvalid && s_axi_bready) r_bvalid <= 1'b0;
    end
  end

  always_comb begin
    w_pop_data = '0;
    for (int i = 0; i < numOut; i++) begin
      if (r_pop_idx == 5'(i)) w_pop_data = 32'(r_out_mem[i]);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_rd_sel)
      c_reg_class:  w_rd_mux = r_class;
      c_reg_layer:  w_rd_mux = r_layer_no;
      c_reg_neuron: w_rd_mux = r_neuron_no;
      c_reg_pop:    w_rd_mux = w_pop_data;
      c_reg_status: w_rd_mux = {19'd0, r_pop_idx, 6'd0, r_intr, r_result_valid};
      c_reg_soft:   w_rd_mux = r_soft_reg;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_rd_fire) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rd_mux;
      end else if (r_arready) begin
        r_arready <= 1'b0;
      end else if (s_axi_arvalid && !r_rvalid) begin
        r_arready <= 1'b1;
      end
      if (r_rvalid && s_axi_rready) r_rvalid <= 1'b0;
    end
  end

  // A new result takes priority over any read side effect in the same cycle.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_class        <= '0;
      r_result_valid <= 1'b0;
      r_intr         <= 1'b0;
      r_pop_idx      <= '0;
      for (int i = 0; i < numOut; i++) r_out_mem[i] <= '0;
    end else if (out_valid) begin
      r_class        <= out_class;
      r_result_valid <= 1'b1;
      r_intr         <= 1'b1;
      r_pop_idx      <= '0;
      for (int i = 0; i < numOut; i++) r_out_mem[i] <= out_vec[i*dataWidth +: dataWidth];
    end else if (w_rd_fire) begin
      if (w_rd_sel == c_reg_class) begin
        r_result_valid <= 1'b0;
        r_intr         <= 1'b0;
      end
      if (w_rd_sel == c_reg_pop) begin
        r_pop_idx <= (r_pop_idx == c_last_idx) ? 5'd0 : r_pop_idx + 5'd1;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_arready = r_arready;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = r_rvalid;
  assign layer_no      = r_layer_no;
  assign neuron_no     = r_neuron_no;
  assign weight_valid  = r_weight_valid;
  assign bias_valid    = r_bias_valid;
  assign weight_value  = r_weight_value;
  assign soft_reset    = r_soft_reg[0];
  assign intr          = r_intr;

endmodule
`default_nettype wire
